// File: rtl/rx_fifo.sv
// Receive buffer behind the UART receiver: acknowledges each ready byte with a
// one-cycle o_rx_re pulse and queues it in a show-ahead circular FIFO.
// Optional fill-level interrupt is built when RX_FIFO_LEVEL_IRQ_EN is defined.
module rx_fifo #(
    parameter int WIDTH_DATA = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int IRQ_LEVEL  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_rx_rdy,
    input  logic [WIDTH_DATA-1:0] i_rx_data,
    output logic                  o_rx_re,
    output logic [WIDTH_DATA-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_rd,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_stall,
    output logic                  o_irq
);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

    state_t                  state, state_nxt;
    logic [WIDTH_DATA-1:0]   mem [1<<DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0]   wptr, rptr;
    logic [DEPTH_LOG2:0]     count, count_nxt;
    logic                    full, wr, pop, stall, stall_nxt;

    assign full = (count == FULL_CNT);
    assign pop  = i_rd && (count != '0);

    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        stall_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_rx_rdy) begin
                    if (!full) begin
                        wr        = 1'b1;
                        state_nxt = S_ACK;
                    end else begin
                        stall_nxt = 1'b1;
                    end
                end
            end
            S_ACK:  state_nxt = S_WAIT;
            // Hold off until the receiver drops its flag so a byte is never taken twice
            S_WAIT: if (!i_rx_rdy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        case ({wr, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= S_IDLE;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            stall <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            stall <= stall_nxt;
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr) mem[wptr] <= i_rx_data;
    end

    assign o_rx_re = (state == S_ACK);
    assign o_data  = mem[rptr];
    assign o_valid = (count != '0);
    assign o_full  = full;
    assign o_count = count;
    assign o_stall = stall;

`ifdef RX_FIFO_LEVEL_IRQ_EN
    localparam logic [DEPTH_LOG2:0] IRQ_CNT = (DEPTH_LOG2+1)'(IRQ_LEVEL);
    logic irq;

    // Driven from next-count so the flag lines up with o_count
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) irq <= 1'b0;
        else         irq <= (count_nxt >= IRQ_CNT);
    end
    assign o_irq = irq;
`else
    assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo: single capture, ordering/wrap, full/stall,
// simultaneous write+pop, empty pop, mid-transfer reset and level irq.
module tb_rx_fifo;
    logic       clk = 1'b0;
    logic       nrst;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_re;
    logic [7:0] data;
    logic       valid;
    logic       rd;
    logic       full;
    logic [4:0] count;
    logic       stall;
    logic       irq;

    int total = 0;
    int fails = 0;
    logic [7:0] q[$];

    rx_fifo dut (
        .i_clk(clk), .i_nrst(nrst), .i_rx_rdy(rx_rdy), .i_rx_data(rx_data),
        .o_rx_re(rx_re), .o_data(data), .o_valid(valid), .i_rd(rd),
        .o_full(full), .o_count(count), .o_stall(stall), .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic irq_exp(input int n);
`ifdef RX_FIFO_LEVEL_IRQ_EN
        return n >= 8;
`else
        return (n < 0);
`endif
    endfunction

    task automatic do_reset();
        nrst = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; rd = 1'b0;
        q.delete();
        step(); step();
        nrst = 1'b1;
        step();
    endtask

    // Receiver model: flag stays up through the ACK cycle, drops after re is seen
    task automatic push(input logic [7:0] d);
        int n = 0;
        rx_rdy = 1'b1; rx_data = d;
        do begin step(); n++; end while (!rx_re && n < 8);
        chk("push_re", rx_re, 1);
        if (rx_re) q.push_back(d);
        chk("push_count", count, q.size());
        chk("push_irq", irq, irq_exp(q.size()));
        step();
        rx_rdy = 1'b0;
        step();
    endtask

    task automatic pop();
        chk("pop_valid", valid, 1);
        chk("pop_data", data, q[0]);
        rd = 1'b1;
        step();
        rd = 1'b0;
        void'(q.pop_front());
        chk("pop_count", count, q.size());
        chk("pop_irq", irq, irq_exp(q.size()));
    endtask

    initial begin
        int k;
        // Reset state
        do_reset();
        chk("rst_re", rx_re, 0);
        chk("rst_valid", valid, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_stall", stall, 0);
        chk("rst_irq", irq, 0);

        // Single byte, ready held high past the acknowledge
        rx_rdy = 1'b1; rx_data = 8'hA5;
        chk("sb_c0_re", rx_re, 0);
        step();
        chk("sb_c1_re", rx_re, 1);
        chk("sb_c1_valid", valid, 1);
        chk("sb_c1_data", data, 8'hA5);
        chk("sb_c1_count", count, 1);
        step();
        chk("sb_c2_re", rx_re, 0);
        step();
        chk("sb_c3_re", rx_re, 0);
        chk("sb_c3_count", count, 1);
        rx_rdy = 1'b0;
        step(); step();
        chk("sb_end_count", count, 1);
        chk("sb_end_data", data, 8'hA5);

        // Ordering and wrap: 20 bytes through a 16-deep buffer
        do_reset();
        for (int i = 0; i < 6; i++) push(8'(i));
        for (int i = 0; i < 3; i++) pop();
        for (int i = 6; i < 16; i++) push(8'(i));
        for (int i = 0; i < 5; i++) pop();
        for (int i = 16; i < 20; i++) push(8'(i));
        while (q.size() > 0) pop();
        chk("wrap_valid", valid, 0);

        // Full and stall
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
        chk("full_flag", full, 1);
        chk("full_count", count, 16);
        rx_rdy = 1'b1; rx_data = 8'h77;
        step();
        chk("stall_set", stall, 1);
        chk("stall_re", rx_re, 0);
        step(); step();
        chk("stall_hold", stall, 1);
        chk("stall_re2", rx_re, 0);
        chk("stall_count", count, 16);
        pop();
        k = 0;
        while (!rx_re && k < 2) begin step(); k++; end
        chk("unstall_re", rx_re, 1);
        chk("unstall_stall", stall, 0);
        chk("unstall_count", count, 16);
        chk("unstall_full", full, 1);
        if (rx_re) q.push_back(8'h77);
        step();
        rx_rdy = 1'b0;
        step();
        while (q.size() > 0) pop();

        // Simultaneous write and pop at count 5
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        rx_rdy = 1'b1; rx_data = 8'h55; rd = 1'b1;
        chk("sim_head", data, 8'h50);
        step();
        rd = 1'b0;
        void'(q.pop_front());
        q.push_back(8'h55);
        chk("sim_re", rx_re, 1);
        chk("sim_count", count, 5);
        chk("sim_newhead", data, 8'h51);
        step();
        rx_rdy = 1'b0;
        step();
        while (q.size() > 0) pop();

        // Pop while empty is ignored
        do_reset();
        rd = 1'b1;
        step(); step();
        rd = 1'b0;
        chk("empty_count", count, 0);
        chk("empty_valid", valid, 0);
        push(8'h11);
        chk("empty_after_data", data, 8'h11);
        pop();

        // Reset in the ACK state with count 3
        do_reset();
        push(8'hC1);
        push(8'hC2);
        rx_rdy = 1'b1; rx_data = 8'hC3;
        step();
        chk("mid_ack", rx_re, 1);
        chk("mid_count3", count, 3);
        nrst = 1'b0;
        #1;
        chk("mid_re", rx_re, 0);
        chk("mid_valid", valid, 0);
        chk("mid_count", count, 0);
        chk("mid_full", full, 0);
        chk("mid_stall", stall, 0);
        chk("mid_irq", irq, 0);
        rx_rdy = 1'b0;
        step();
        nrst = 1'b1;
        q.delete();
        step();
        chk("mid_post_count", count, 0);

        // Level irq: rises on the 8th byte, falls on the next pop
        for (int i = 0; i < 7; i++) push(8'(8'h80 + i));
        chk("irq_at7", irq, irq_exp(7));
        push(8'h87);
        chk("irq_at8", irq, irq_exp(8));
        pop();
        chk("irq_at7b", irq, irq_exp(7));
        while (q.size() > 0) pop();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Watches the receiver's ready flag, pulls each completed byte out via a one-cycle read-enable pulse, and stores it in a circular FIFO.
- Presents bytes to the host side with show-ahead (first-word-fall-through) semantics, so the receiver is freed quickly and host read latency is decoupled from the serial line.

Parameters:
- WIDTH_DATA, 8, width of one received character; matches the receiver.
- DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16).
- IRQ_LEVEL, 8, fill level at or above which o_irq asserts (optional feature only); legal range 1..2**DEPTH_LOG2.

Ports:
- i_clk, input, 1, system clock; same clock as the receiver.
- i_nrst, input, 1, asynchronous active-low reset.
- i_rx_rdy, input, 1, receiver "byte ready" flag (level).
- i_rx_data, input, WIDTH_DATA, receiver data; stable while i_rx_rdy=1.
- o_rx_re, output, 1, one-cycle read-enable pulse to receiver; clears its ready flag.
- o_data, output, WIDTH_DATA, oldest stored byte (show-ahead).
- o_valid, output, 1, FIFO not empty; o_data meaningful.
- i_rd, input, 1, host pop request.
- o_full, output, 1, count equals 2**DEPTH_LOG2.
- o_count, output, DEPTH_LOG2+1, current fill level.
- o_stall, output, 1, receiver has a byte waiting but FIFO is full.
- o_irq, output, 1, fill-level interrupt (see Optional Feature).

Behaviour:
- Reset (i_nrst=0, async):
  - Pointers and count cleared; capture FSM in IDLE.
  - o_rx_re=0, o_valid=0, o_full=0, o_count=0, o_stall=0, o_irq=0.
  - o_data is don't-care; memory contents are not reset.
  - Reset mid-transfer discards all stored bytes and any pending acknowledge.
- Capture FSM states:
  - IDLE: if i_rx_rdy=1 and not full, at the next edge write i_rx_data to mem[wptr], advance wptr, set o_rx_re=1, go to ACK. If i_rx_rdy=1 and full, remain in IDLE with no write and no pulse; the byte stays in the receiver.
  - ACK: o_rx_re=1 for exactly this cycle. At the next edge drop o_rx_re and go to WAIT.
  - WAIT: remain until i_rx_rdy=0, then go to IDLE. This guarantees one byte is never captured twice.
- Timing: a ready flag first seen in cycle N is written at edge N+1; o_valid rises in cycle N+1 if the FIFO was empty.
- Read side:
  - o_valid = count != 0; o_data = mem[rptr] combinationally from the registered pointer.
  - A pop occurs when i_rd=1 and o_valid=1; rptr advances at the edge.
  - i_rd while empty is ignored: no pointer change, no underflow.
- Pointers: DEPTH_LOG2 bits each, natural wrap-around from 2**DEPTH_LOG2-1 to 0.
- Count update:
  - Write and pop in the same cycle: count unchanged; the pop returns the old head.
  - Write only: +1. Pop only: -1.
  - Count never exceeds 2**DEPTH_LOG2 and never goes below 0.
- Full / stall:
  - o_full = count == 2**DEPTH_LOG2.
  - o_stall is registered: set when IDLE, i_rx_rdy=1 and full; cleared otherwise.
  - A pop while full and stalled frees space, and capture proceeds on the following cycle.
- All outputs except o_data are registered or derived from registered state only.

Optional Feature:
- Macro: RX_FIFO_LEVEL_IRQ_EN.
- Defined: o_irq is a registered flag equal to (count >= IRQ_LEVEL), updated every cycle from next-count, so it tracks count with no extra lag.
- Undefined: o_irq is tied to 0 and no comparator is built.

Test Plan:
- Single byte: reset, i_rx_rdy=1 with i_rx_data=0xA5 from cycle 0, rx model clears rdy one cycle after o_rx_re -> o_rx_re high exactly 1 cycle (cycle 1), o_valid=1 and o_data=0xA5 in cycle 1, o_count=1, no second capture while rdy is still high.
- Ordering and wrap: push 20 bytes 0x00..0x13 while popping in bursts -> pop order is strictly 0x00..0x13, pointers wrap correctly.
- Full and stall: push 16 bytes with no reads, then present 0x77 -> o_full=1, o_stall=1, no o_rx_re. Then pop once -> 0x77 is captured within 2 cycles, o_stall=0, o_count=16.
- Simultaneous write and pop at count=5 -> count stays 5, popped byte is the old head.
- Empty pop and mid-operation reset: i_rd=1 while empty -> count stays 0. Assert i_nrst=0 in the ACK state with count=3 -> all outputs at reset values immediately, o_rx_re=0.
- With RX_FIFO_LEVEL_IRQ_EN and IRQ_LEVEL=8: push 8 bytes -> o_irq rises in the same cycle count reaches 8; pop 1 -> o_irq falls. Without the macro, o_irq stays 0 throughout.
